// File: rtl/uart_cmd_master.sv
// Host-side initiator for the UART register/ALU command protocol: serialises one
// command into frame bytes toward a UART TX and assembles the response bytes from RX.
module uart_cmd_master #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned TO_WIDTH    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VLD,
    output logic        CMD_RDY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA,
    input  logic [7:0]  CMD_OPB,
    input  logic [3:0]  CMD_FUN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_RDY,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [15:0] RSP_DATA,
    output logic        DONE,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        CT_WR   = 2'b00,
        CT_RD   = 2'b01,
        CT_ALU  = 2'b10,
        CT_ALUN = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        DONE_ST
    } state_e;

    typedef struct packed {
        cmd_type_e  typ;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opb;
        logic [3:0] fun;
    } cmd_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);

    state_e              state, state_nxt;
    cmd_t                cmd, cmd_nxt;
    logic [1:0]          idx, idx_nxt;
    logic                rsp_cnt, rsp_cnt_nxt;
    logic [TO_WIDTH-1:0] to_cnt, to_cnt_nxt;
    logic [15:0]         rsp, rsp_nxt;
    logic                timeout_q, timeout_nxt;
    logic [7:0]          tx_byte;
    logic [1:0]          last_idx;

    // Frame byte for the current index, and the index of the final byte.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        tx_byte  = 8'h00;
        last_idx = 2'd0;
        case (cmd.typ)
            CT_WR: begin
                last_idx = 2'd2;
                case (idx)
                    2'd0:    tx_byte = 8'hAA;
                    2'd1:    tx_byte = {4'h0, cmd.addr};
                    default: tx_byte = cmd.data;
                endcase
            end
            CT_RD: begin
                last_idx = 2'd1;
                tx_byte  = (idx == 2'd0) ? 8'hBB : {4'h0, cmd.addr};
            end
            CT_ALU: begin
                last_idx = 2'd3;
                case (idx)
                    2'd0:    tx_byte = 8'hCC;
                    2'd1:    tx_byte = cmd.data;
                    2'd2:    tx_byte = cmd.opb;
                    default: tx_byte = {4'h0, cmd.fun};
                endcase
            end
            default: begin
                last_idx = 2'd1;
                tx_byte  = (idx == 2'd0) ? 8'hDD : {4'h0, cmd.fun};
            end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd;
        idx_nxt     = idx;
        rsp_cnt_nxt = rsp_cnt;
        to_cnt_nxt  = to_cnt;
        rsp_nxt     = rsp;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_VLD) begin
                    cmd_nxt.typ  = cmd_type_e'(CMD_TYPE);
                    cmd_nxt.addr = CMD_ADDR;
                    cmd_nxt.data = CMD_DATA;
                    cmd_nxt.opb  = CMD_OPB;
                    cmd_nxt.fun  = CMD_FUN;
                    idx_nxt      = 2'd0;
                    rsp_cnt_nxt  = 1'b0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (TX_RDY) begin
                    if (idx == last_idx) begin
                        idx_nxt    = 2'd0;
                        to_cnt_nxt = '0;
                        state_nxt  = (cmd.typ == CT_WR) ? DONE_ST : WAIT_RSP;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            WAIT_RSP: begin
                // A byte arriving on the expiry edge takes priority over the timeout.
                if (RX_D_VLD) begin
                    to_cnt_nxt = '0;
                    if (cmd.typ == CT_RD) begin
                        rsp_nxt   = {8'h00, RX_P_DATA};
                        state_nxt = DONE_ST;
                    end else if (!rsp_cnt) begin
                        rsp_nxt[7:0] = RX_P_DATA;
                        rsp_cnt_nxt  = 1'b1;
                    end else begin
                        rsp_nxt[15:8] = RX_P_DATA;
                        state_nxt     = DONE_ST;
                    end
                end else if (to_cnt == TO_LAST) begin
                    to_cnt_nxt  = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cmd       <= '0;
            idx       <= 2'd0;
            rsp_cnt   <= 1'b0;
            to_cnt    <= '0;
            rsp       <= 16'h0000;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            idx       <= idx_nxt;
            rsp_cnt   <= rsp_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            rsp       <= rsp_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign CMD_RDY   = (state == IDLE);
    assign TX_D_VLD  = (state == SEND);
    assign TX_P_DATA = (state == SEND) ? tx_byte : 8'h00;
    assign RSP_DATA  = rsp;
    assign DONE      = (state == DONE_ST);
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed self-checking bench for uart_cmd_master with a short response timeout.
module tb_uart_cmd_master;

    localparam int unsigned TO_CYC = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VLD;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_DATA;
    logic [7:0]  CMD_OPB;
    logic [3:0]  CMD_FUN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_RDY;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] RSP_DATA;
    logic        DONE;
    logic        TIMEOUT;

    int n_checks = 0;
    int n_err    = 0;

    uart_cmd_master #(.TIMEOUT_CYC(TO_CYC), .TO_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_RDY(TX_RDY),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RSP_DATA(RSP_DATA), .DONE(DONE), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one command for the accepting edge, then drops CMD_VLD.
    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] b, input logic [3:0] f);
        CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d; CMD_OPB = b; CMD_FUN = f;
        CMD_VLD  = 1'b1;
        check("cmd_rdy_before", CMD_RDY, 1'b1);
        tick();
        CMD_VLD = 1'b0;
        check("cmd_rdy_after", CMD_RDY, 1'b0);
    endtask

    // Expects n bytes (frame[31:24] first), stalling TX_RDY low 'stall' cycles before each.
    task automatic tx_frame(input logic [31:0] frame, input int n, input int stall);
        logic [7:0] exp_b;
        for (int i = 0; i < n; i++) begin
            exp_b  = frame[31-8*i -: 8];
            TX_RDY = 1'b0;
            for (int s = 0; s < stall; s++) begin
                check("tx_vld_stall", TX_D_VLD, 1'b1);
                check("tx_data_stall", TX_P_DATA, exp_b);
                tick();
            end
            TX_RDY = 1'b1;
            check("tx_vld", TX_D_VLD, 1'b1);
            check("tx_data", TX_P_DATA, exp_b);
            tick();
        end
        check("tx_vld_end", TX_D_VLD, 1'b0);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    initial begin
        RST = 1'b0; CMD_VLD = 1'b0; CMD_TYPE = 2'b00; CMD_ADDR = 4'h0; CMD_DATA = 8'h00;
        CMD_OPB = 8'h00; CMD_FUN = 4'h0; TX_RDY = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cmd_rdy", CMD_RDY, 1'b1);
        check("rst_tx_vld", TX_D_VLD, 1'b0);
        check("rst_tx_data", TX_P_DATA, 8'h00);
        check("rst_rsp", RSP_DATA, 16'h0000);
        check("rst_done", DONE, 1'b0);
        check("rst_timeout", TIMEOUT, 1'b0);
        RST = 1'b1;
        tick();

        // RF write: AA 05 3C back to back, DONE one cycle later.
        send_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0);
        tx_frame(32'hAA053C00, 3, 0);
        check("wr_done", DONE, 1'b1);
        check("wr_rsp", RSP_DATA, 16'h0000);
        tick();
        check("wr_done_clr", DONE, 1'b0);
        check("wr_idle", CMD_RDY, 1'b1);

        // RF read, with a competing CMD_VLD held during the frame that must be ignored.
        send_cmd(2'b01, 4'h2, 8'h00, 8'h00, 4'h0);
        CMD_VLD = 1'b1; CMD_TYPE = 2'b00; CMD_ADDR = 4'hF;
        tx_frame(32'hBB020000, 2, 0);
        CMD_VLD = 1'b0;
        check("rd_wait_done", DONE, 1'b0);
        rx_byte(8'h81);
        check("rd_done", DONE, 1'b1);
        check("rd_rsp", RSP_DATA, 16'h0081);
        tick();
        check("rd_idle", CMD_RDY, 1'b1);

        // ALU with operands, response 46 then 00 after a short gap.
        send_cmd(2'b10, 4'h0, 8'h12, 8'h34, 4'h0);
        tx_frame(32'hCC123400, 4, 0);
        tick();
        tick();
        rx_byte(8'h46);
        check("alu_partial_done", DONE, 1'b0);
        check("alu_partial_rsp", RSP_DATA, 16'h0046);
        rx_byte(8'h00);
        check("alu_done", DONE, 1'b1);
        check("alu_rsp", RSP_DATA, 16'h0046);
        tick();

        // ALU without operands under 5-cycle backpressure per byte; response 5A then A5.
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'h2);
        tx_frame(32'hDD020000, 2, 5);
        rx_byte(8'h5A);
        rx_byte(8'hA5);
        check("alun_done", DONE, 1'b1);
        check("alun_rsp", RSP_DATA, 16'hA55A);
        tick();

        // RF read with no response: TIMEOUT exactly TO_CYC cycles after the last transfer.
        send_cmd(2'b01, 4'h3, 8'h00, 8'h00, 4'h0);
        tx_frame(32'hBB030000, 2, 0);
        for (int k = 1; k < TO_CYC; k++) begin
            check("to_early", TIMEOUT, 1'b0);
            tick();
        end
        check("to_early_last", TIMEOUT, 1'b0);
        tick();
        check("to_pulse", TIMEOUT, 1'b1);
        check("to_no_done", DONE, 1'b0);
        check("to_rsp_kept", RSP_DATA, 16'hA55A);
        tick();
        check("to_pulse_clr", TIMEOUT, 1'b0);
        check("to_idle", CMD_RDY, 1'b1);

        // Byte on the expiry edge wins over the timeout.
        send_cmd(2'b01, 4'h4, 8'h00, 8'h00, 4'h0);
        tx_frame(32'hBB040000, 2, 0);
        repeat (TO_CYC - 1) tick();
        rx_byte(8'h3E);
        check("edge_done", DONE, 1'b1);
        check("edge_no_to", TIMEOUT, 1'b0);
        check("edge_rsp", RSP_DATA, 16'h003E);
        tick();
        check("edge_no_to_late", TIMEOUT, 1'b0);

        // Stray RX in IDLE and during SEND is ignored.
        rx_byte(8'hFF);
        check("stray_idle_rsp", RSP_DATA, 16'h003E);
        send_cmd(2'b01, 4'h9, 8'h00, 8'h00, 4'h0);
        TX_RDY = 1'b0;
        rx_byte(8'hFF);
        check("stray_send_rsp", RSP_DATA, 16'h003E);
        tx_frame(32'hBB090000, 2, 0);
        rx_byte(8'h07);
        check("stray_done", DONE, 1'b1);
        check("stray_rsp", RSP_DATA, 16'h0007);
        tick();

        // Reset mid-frame drops TX_D_VLD at once.
        send_cmd(2'b00, 4'h1, 8'h55, 8'h00, 4'h0);
        tick();
        check("pre_rst_vld", TX_D_VLD, 1'b1);
        RST = 1'b0;
        #1;
        check("mid_rst_vld", TX_D_VLD, 1'b0);
        check("mid_rst_rdy", CMD_RDY, 1'b1);
        check("mid_rst_data", TX_P_DATA, 8'h00);
        check("mid_rst_rsp", RSP_DATA, 16'h0000);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check("post_rst_vld", TX_D_VLD, 1'b0);
        check("post_rst_done", DONE, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
